branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
// - Control-side partner of the branch comparator: drives BrUn to it, consumes BEQ/BLT, resolves
//   B-type conditions in EX, detects mispredictions, issues a registered PC redirect plus a
//   multi-cycle pipeline flush, and hosts an optional 2-bit branch history table (BHT) for IF.
// PARAMETERS
// - FLUSH_CYCLES  2   cycles flush is held after a redirect (1..7)
// - BHT_IDX_W     4   BHT index width; 2**BHT_IDX_W entries, indexed by pc[BHT_IDX_W+1:2]
// - CNT_W         16  width of the saturating statistics counters
// PORTS
// - clk            in   1        clock, rising edge
// - rst            in   1        synchronous reset, active-high
// - br_valid       in   1        EX stage holds a B-type instruction this cycle
// - br_funct3      in   3        funct3 of that instruction
// - br_pc          in   32       PC of that instruction
// - br_target      in   32       computed target (pc + imm)
// - ex_pred_taken  in   1        prediction carried down the pipe with the instruction
// - BEQ            in   1        comparator equal result
// - BLT            in   1        comparator less-than result
// - BrUn           out  1        unsigned-compare select to comparator (combinational)
// - if_pc          in   32       fetch PC for BHT lookup
// - if_pred_taken  out  1        BHT prediction for if_pc (combinational read)
// - redirect       out  1        one-cycle pulse: load redirect_pc into PC
// - redirect_pc    out  32       corrected PC, valid while redirect=1
// - flush          out  1        kill IF/ID/EX wrong-path instructions
// - illegal_br     out  1        one-cycle pulse: funct3 010/011 seen on a valid branch
// - br_count       out  CNT_W    resolved branches, saturating
// - mispred_count  out  CNT_W    mispredictions, saturating
// BEHAVIOUR
// - Reset: redirect=0, redirect_pc=0, flush=0, illegal_br=0, counters=0, flush counter=0,
//   all BHT entries=2'b01 (weakly not-taken). BrUn/if_pred_taken are combinational.
// - BrUn = br_valid & br_funct3[1] (same cycle as operands; no register).
// - Condition: 000 taken=BEQ; 001 ~BEQ; 100 BLT; 101 ~BLT; 110 BLT; 111 ~BLT.
//   010/011: taken=0, no redirect, no BHT update, not counted; illegal_br pulses next cycle.
// - Accepted branch = br_valid & ~flush. Branches seen while flush=1 are wrong-path: ignored.
// - Mispredict = accepted & (taken != ex_pred_taken). Next edge: redirect=1 for one cycle,
//   redirect_pc = taken ? br_target : br_pc+4 (mod 2**32, wrap ok); flush asserts same cycle
//   as redirect and holds exactly FLUSH_CYCLES cycles via down-counter, then deasserts.
// - Correct prediction: no redirect, no flush. Latency resolve->redirect = 1 cycle.
// - br_count +1 per accepted legal branch; mispred_count +1 per mispredict; both stop at all-ones.
// - BHT update on accepted legal branch, registered at the same edge: taken -> +1 sat at 11,
//   not taken -> -1 sat at 00. Prediction = counter[1].
// - Same-cycle lookup and update of one index: lookup returns pre-update value (no bypass).
// - rst asserted mid-flush: flush and counter clear next edge; pending redirect dropped.
// CONFIGURATION
// - BRANCH_BHT_EN defined: BHT as above; ex_pred_taken compared as given.
// - BRANCH_BHT_EN undefined: no BHT storage; if_pred_taken=0; ex_pred_taken ignored and
//   treated as 0 (static not-taken), so every taken branch redirects to br_target.
// TESTING
// - funct3=000, BEQ=1, pred=0, pc=0x100, tgt=0x140 -> next cycle redirect=1, redirect_pc=0x140,
//   flush high 2 cycles, mispred_count=1, BHT[0] 01->10.
// - funct3=110 and 111 -> BrUn=1 same cycle; funct3=100 -> BrUn=0; br_valid=0 -> BrUn=0.
// - funct3=101, BLT=1, pred=1, pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap), flush asserted.
// - Branch with br_valid=1 during flush, mispredicting -> no redirect, counters/BHT unchanged.
// - funct3=011 valid -> illegal_br one pulse, no redirect, br_count unchanged; rst pulse mid-flush
//   -> flush=0 after next edge, counters=0, BHT back to 01.
// - BHT_EN: same PC taken 3x -> 01->10->11->11; if_pc lookup same cycle as update sees old value;
//   without macro if_pred_taken stays 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution for EX: condition evaluation, misprediction redirect, multi-cycle flush
// and statistics. Optional 2-bit BHT for fetch prediction when BRANCH_BHT_EN is defined.
module branch_resolve_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned BHT_IDX_W    = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic [2:0]       br_funct3,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      br_target,
  input  logic             ex_pred_taken,
  input  logic             BEQ,
  input  logic             BLT,
  output logic             BrUn,
  input  logic [31:0]      if_pc,
  output logic             if_pred_taken,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  logic [2:0] flush_cnt;
  logic       taken;
  logic       legal;
  logic       accepted;
  logic       resolve;
  logic       pred;
  logic       mispredict;

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (br_funct3)
      3'b000:         taken = BEQ;
      3'b001:         taken = ~BEQ;
      3'b100, 3'b110: taken = BLT;
      3'b101, 3'b111: taken = ~BLT;
      default:        legal = 1'b0;
    endcase
  end

  assign BrUn       = br_valid & br_funct3[1];
  assign flush      = (flush_cnt != '0);
  assign accepted   = br_valid & ~flush;
  assign resolve    = accepted & legal;
  // Illegal encodings never redirect, even if the carried prediction said taken.
  assign mispredict = resolve & (taken != pred);

`ifdef BRANCH_BHT_EN
  localparam int unsigned BHT_N = 2 ** BHT_IDX_W;

  logic [1:0]           bht [BHT_N];
  logic [BHT_IDX_W-1:0] upd_idx;
  logic [BHT_IDX_W-1:0] rd_idx;
  logic                 unused_pc_bits;

  assign upd_idx        = br_pc[BHT_IDX_W+1:2];
  assign rd_idx         = if_pc[BHT_IDX_W+1:2];
  assign if_pred_taken  = bht[rd_idx][1];
  assign pred           = ex_pred_taken;
  assign unused_pc_bits = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (resolve) begin
      if (taken && bht[upd_idx] != 2'b11)
        bht[upd_idx] <= bht[upd_idx] + 2'b01;
      else if (!taken && bht[upd_idx] != 2'b00)
        bht[upd_idx] <= bht[upd_idx] - 2'b01;
    end
  end
`else
  logic unused_pred_inputs;

  assign if_pred_taken      = 1'b0;
  assign pred               = 1'b0;
  assign unused_pred_inputs = ^{if_pc, ex_pred_taken};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect      <= 1'b0;
      redirect_pc   <= '0;
      flush_cnt     <= '0;
      illegal_br    <= 1'b0;
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      redirect   <= mispredict;
      illegal_br <= accepted & ~legal;
      if (mispredict)
        redirect_pc <= taken ? br_target : br_pc + 32'd4;
      if (mispredict)
        flush_cnt <= FLUSH_LOAD;
      else if (flush)
        flush_cnt <= flush_cnt - 3'd1;
      if (resolve && br_count != '1)
        br_count <= br_count + CNT_W'(1);
      if (mispredict && mispred_count != '1)
        mispred_count <= mispred_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; redirects checked through an expected-PC queue.
// Narrow counters (CNT_W=3) so saturation is reachable.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [2:0]  br_funct3;
  logic [31:0] br_pc;
  logic [31:0] br_target;
  logic        ex_pred_taken;
  logic        BEQ;
  logic        BLT;
  logic        BrUn;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        illegal_br;
  logic [2:0]  br_count;
  logic [2:0]  mispred_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  exp_br  = 3'd0;
  logic [2:0]  exp_mis = 3'd0;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .FLUSH_CYCLES(2),
    .BHT_IDX_W   (4),
    .CNT_W       (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .br_valid     (br_valid),
    .br_funct3    (br_funct3),
    .br_pc        (br_pc),
    .br_target    (br_target),
    .ex_pred_taken(ex_pred_taken),
    .BEQ          (BEQ),
    .BLT          (BLT),
    .BrUn         (BrUn),
    .if_pc        (if_pc),
    .if_pred_taken(if_pred_taken),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .flush        (flush),
    .illegal_br   (illegal_br),
    .br_count     (br_count),
    .mispred_count(mispred_count)
  );

  // Scoreboard: every observed redirect must match the oldest expected PC.
  always @(negedge clk) begin
    if (redirect === 1'b1) begin
      logic [31:0] e;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_redirect: got redirect_pc=%h, expected no redirect", redirect_pc);
      end else begin
        e = exp_q.pop_front();
        if (redirect_pc !== e) begin
          n_fail++;
          $display("FAIL sb_redirect_pc: got %h, expected %h", redirect_pc, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] sat(input logic [2:0] c);
    return (c == 3'd7) ? c : c + 3'd1;
  endfunction

  task automatic drive(input logic [2:0] f3, input logic beq, input logic blt,
                       input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
    br_valid = 1'b1; br_funct3 = f3; BEQ = beq; BLT = blt;
    ex_pred_taken = pred; br_pc = pc; br_target = tgt;
  endtask

  task automatic idle();
    br_valid = 1'b0; br_funct3 = 3'b000; BEQ = 1'b0; BLT = 1'b0;
    ex_pred_taken = 1'b0; br_pc = '0; br_target = '0;
  endtask

  task automatic wait_flush_clear(input string tag);
    for (int i = 0; i < 8 && flush !== 1'b0; i++) @(negedge clk);
    n_tests++;
    if (flush !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_flush_timeout: flush=%b, expected 0 within 8 cycles", tag, flush);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); if_pc = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({redirect, flush, illegal_br, if_pred_taken, BrUn} !== 5'b0 || redirect_pc !== '0 ||
        br_count !== 3'd0 || mispred_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: redirect=%b flush=%b illegal=%b ifpred=%b brun=%b pc=%h br=%0d mis=%0d, expected all 0",
               redirect, flush, illegal_br, if_pred_taken, BrUn, redirect_pc, br_count, mispred_count);
    end
    rst = 1'b0;
    exp_br = 3'd0; exp_mis = 3'd0;
  endtask

  task automatic test_brun();
    logic [2:0] f3s [4] = '{3'b110, 3'b111, 3'b100, 3'b110};
    logic       vs  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      br_valid = vs[i]; br_funct3 = f3s[i];
      #1;
      n_tests++;
      if (BrUn !== exp[i]) begin
        n_fail++;
        $display("FAIL brun_%0d: funct3=%b valid=%b BrUn=%b, expected %b", i, f3s[i], vs[i], BrUn, exp[i]);
      end
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_mispredict();
    logic exp_if;
`ifdef BRANCH_BHT_EN
    exp_if = 1'b1;
`else
    exp_if = 1'b0;
`endif
    drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h140);
    if_pc = 32'h100;
    exp_q.push_back(32'h140); exp_br = sat(exp_br); exp_mis = sat(exp_mis);
    @(negedge clk); idle();
    n_tests++;
    if (redirect !== 1'b1 || flush !== 1'b1 || br_count !== exp_br || mispred_count !== exp_mis) begin
      n_fail++;
      $display("FAIL mispredict_cycle1: redirect=%b flush=%b br=%0d mis=%0d, expected 1 1 %0d %0d",
               redirect, flush, br_count, mispred_count, exp_br, exp_mis);
    end
    n_tests++;
    if (if_pred_taken !== exp_if) begin
      n_fail++;
      $display("FAIL mispredict_bht0: if_pred_taken=%b, expected %b", if_pred_taken, exp_if);
    end
    @(negedge clk);
    n_tests++;
    if (redirect !== 1'b0 || flush !== 1'b1) begin
      n_fail++;
      $display("FAIL mispredict_cycle2: redirect=%b flush=%b, expected 0 1", redirect, flush);
    end
    @(negedge clk);
    n_tests++;
    if (flush !== 1'b0) begin
      n_fail++;
      $display("FAIL mispredict_flush_len: flush=%b, expected 0 after 2 cycles", flush);
    end
  endtask

  task automatic test_flush_ignore();
    drive(3'b001, 1'b0, 1'b0, 1'b0, 32'h200, 32'h280);
    exp_q.push_back(32'h280); exp_br = sat(exp_br); exp_mis = sat(exp_mis);
    @(negedge clk);
    n_tests++;
    if (redirect !== 1'b1 || flush !== 1'b1) begin
      n_fail++;
      $display("FAIL flushign_trigger: redirect=%b flush=%b, expected 1 1", redirect, flush);
    end
    drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h204, 32'h300);
    @(negedge clk); idle();
    n_tests++;
    if (redirect !== 1'b0 || flush !== 1'b1 || br_count !== exp_br || mispred_count !== exp_mis) begin
      n_fail++;
      $display("FAIL flushign_wrongpath: redirect=%b flush=%b br=%0d mis=%0d, expected 0 1 %0d %0d",
               redirect, flush, br_count, mispred_count, exp_br, exp_mis);
    end
    @(negedge clk);
    if_pc = 32'h204;
    #1;
    n_tests++;
    if (flush !== 1'b0 || redirect !== 1'b0 || if_pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL flushign_after: flush=%b redirect=%b ifpred=%b, expected 0 0 0",
               flush, redirect, if_pred_taken);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic exp_red;
    drive(3'b101, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h10);
    exp_br = sat(exp_br);
`ifdef BRANCH_BHT_EN
    exp_red = 1'b1;
    exp_q.push_back(32'h0000_0000); exp_mis = sat(exp_mis);
`else
    exp_red = 1'b0;
`endif
    @(negedge clk); idle();
    n_tests++;
    if (redirect !== exp_red || flush !== exp_red || br_count !== exp_br || mispred_count !== exp_mis) begin
      n_fail++;
      $display("FAIL wrap: redirect=%b flush=%b br=%0d mis=%0d, expected %b %b %0d %0d",
               redirect, flush, br_count, mispred_count, exp_red, exp_red, exp_br, exp_mis);
    end
    wait_flush_clear("wrap");
  endtask

  task automatic test_illegal();
    drive(3'b011, 1'b1, 1'b0, 1'b0, 32'h300, 32'h400);
    @(negedge clk); idle();
    n_tests++;
    if (illegal_br !== 1'b1 || redirect !== 1'b0 || br_count !== exp_br || mispred_count !== exp_mis) begin
      n_fail++;
      $display("FAIL illegal_pulse: illegal=%b redirect=%b br=%0d mis=%0d, expected 1 0 %0d %0d",
               illegal_br, redirect, br_count, mispred_count, exp_br, exp_mis);
    end
    @(negedge clk);
    n_tests++;
    if (illegal_br !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_width: illegal=%b, expected 0 on second cycle", illegal_br);
    end
  endtask

  task automatic test_bht();
    logic exp_pre [3];
    logic exp_red [3];
    logic last_red, last_if;
`ifdef BRANCH_BHT_EN
    exp_pre = '{1'b0, 1'b1, 1'b1};
    exp_red = '{1'b1, 1'b0, 1'b0};
    last_red = 1'b1; last_if = 1'b1;
`else
    exp_pre = '{1'b0, 1'b0, 1'b0};
    exp_red = '{1'b1, 1'b1, 1'b1};
    last_red = 1'b0; last_if = 1'b0;
`endif
    if_pc = 32'h28;
    for (int k = 0; k < 3; k++) begin
      drive(3'b000, 1'b1, 1'b0, (k > 0), 32'h28, 32'h80);
      exp_br = sat(exp_br);
      if (exp_red[k]) begin
        exp_q.push_back(32'h80); exp_mis = sat(exp_mis);
      end
      #1;
      n_tests++;
      if (if_pred_taken !== exp_pre[k]) begin
        n_fail++;
        $display("FAIL bht_lookup_%0d: if_pred_taken=%b, expected %b", k, if_pred_taken, exp_pre[k]);
      end
      @(negedge clk); idle();
      n_tests++;
      if (redirect !== exp_red[k] || br_count !== exp_br || mispred_count !== exp_mis) begin
        n_fail++;
        $display("FAIL bht_resolve_%0d: redirect=%b br=%0d mis=%0d, expected %b %0d %0d",
                 k, redirect, br_count, mispred_count, exp_red[k], exp_br, exp_mis);
      end
      wait_flush_clear("bht");
    end
    // Not-taken from a saturated entry: 11 -> 10 keeps predicting taken.
    drive(3'b000, 1'b0, 1'b0, 1'b1, 32'h28, 32'h80);
    exp_br = sat(exp_br);
    if (last_red) begin
      exp_q.push_back(32'h2C); exp_mis = sat(exp_mis);
    end
    @(negedge clk); idle();
    n_tests++;
    if (redirect !== last_red || mispred_count !== exp_mis) begin
      n_fail++;
      $display("FAIL bht_nottaken: redirect=%b mis=%0d, expected %b %0d", redirect, mispred_count, last_red, exp_mis);
    end
    wait_flush_clear("bht_nt");
    n_tests++;
    if (if_pred_taken !== last_if) begin
      n_fail++;
      $display("FAIL bht_saturated: if_pred_taken=%b, expected %b", if_pred_taken, last_if);
    end
  endtask

  task automatic test_reset_mid_flush();
    drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h28, 32'h90);
    rst = 1'b1;
    @(negedge clk); idle(); rst = 1'b0;
    exp_br = 3'd0; exp_mis = 3'd0;
    n_tests++;
    if (redirect !== 1'b0 || flush !== 1'b0 || br_count !== 3'd0 || mispred_count !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_drop_redirect: redirect=%b flush=%b br=%0d mis=%0d, expected 0 0 0 0",
               redirect, flush, br_count, mispred_count);
    end
    drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h28, 32'h90);
    exp_q.push_back(32'h90); exp_br = sat(exp_br); exp_mis = sat(exp_mis);
    @(negedge clk); idle();
    n_tests++;
    if (redirect !== 1'b1 || flush !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_trigger: redirect=%b flush=%b, expected 1 1", redirect, flush);
    end
    rst = 1'b1; if_pc = 32'h28;
    @(negedge clk); rst = 1'b0;
    exp_br = 3'd0; exp_mis = 3'd0;
    n_tests++;
    if (flush !== 1'b0 || redirect !== 1'b0 || br_count !== 3'd0 || mispred_count !== 3'd0 ||
        if_pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_flush: flush=%b redirect=%b br=%0d mis=%0d ifpred=%b, expected 0 0 0 0 0",
               flush, redirect, br_count, mispred_count, if_pred_taken);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) begin
      drive(3'b001, 1'b1, 1'b0, 1'b0, 32'h400 + 32'(i * 4), 32'h800);
      exp_br = sat(exp_br);
      @(negedge clk);
      n_tests++;
      if (br_count !== exp_br || redirect !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_count_%0d: br=%0d redirect=%b, expected %0d 0", i, br_count, redirect, exp_br);
      end
    end
    idle();
    for (int i = 0; i < 9; i++) begin
      drive(3'b100, 1'b0, 1'b1, 1'b0, 32'h500, 32'h600 + 32'(i * 4));
      exp_q.push_back(32'h600 + 32'(i * 4)); exp_mis = sat(exp_mis);
      @(negedge clk); idle();
      n_tests++;
      if (mispred_count !== exp_mis || br_count !== 3'd7) begin
        n_fail++;
        $display("FAIL sat_mis_%0d: mis=%0d br=%0d, expected %0d 7", i, mispred_count, br_count, exp_mis);
      end
      wait_flush_clear("sat");
    end
  endtask

  initial begin
    idle(); rst = 1'b1; if_pc = '0;
    test_reset();
    test_brun();
    test_mispredict();
    test_flush_ignore();
    test_wrap();
    test_illegal();
    test_bht();
    test_reset_mid_flush();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_missing_redirect: %0d expected redirects never seen, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
